// File: rtl/inst_encoder_if.sv
// Request and instruction-memory write bundle for inst_encoder.
interface inst_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic [5:0]  req_funct;
  logic [15:0] req_imm;
  logic [25:0] req_target;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_ready;

  modport master (
    output req_valid, req_op, req_rs, req_rt, req_rd,
    output req_funct, req_imm, req_target, imem_ready,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  req_valid, req_op, req_rs, req_rt, req_rd,
    input  req_funct, req_imm, req_target, imem_ready,
    output req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/inst_encoder.sv
// MIPS instruction encoder with FIFO streaming into imem write port.
// Optional checks enabled by INST_ENCODER_CHECK_EN.
module inst_encoder #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_base,
  input  logic [31:0]   base_addr,
  inst_encoder_if.slave bus,
  output logic [15:0]   word_count,
  output logic          done,
  output logic          err_flag
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   wcnt_q, wcnt_d;
  logic          err_q, err_d;
  logic [31:0]   word;
  logic          full, empty, acc, is_end;
  logic          drop, enq, deq, load_ok;

  always_comb begin
    word = 32'h0;
    unique case (bus.req_op)
      4'd0:  word = {6'h00, bus.req_rs, bus.req_rt,
                    bus.req_rd, 5'd0, bus.req_funct};
      4'd1:  word = {6'h23, bus.req_rs, bus.req_rt, bus.req_imm};
      4'd2:  word = {6'h2B, bus.req_rs, bus.req_rt, bus.req_imm};
      4'd3:  word = {6'h04, bus.req_rs, bus.req_rt, bus.req_imm};
      4'd4:  word = {6'h05, bus.req_rs, bus.req_rt, bus.req_imm};
      4'd5:  word = {6'h01, bus.req_rs, 5'd1, bus.req_imm};
      4'd6:  word = {6'h07, bus.req_rs, 5'd0, bus.req_imm};
      4'd7:  word = {6'h06, bus.req_rs, 5'd0, bus.req_imm};
      4'd8:  word = {6'h01, bus.req_rs, 5'd0, bus.req_imm};
      4'd9:  word = {6'h02, bus.req_target};
      4'd10: word = {6'h03, bus.req_target};
      4'd11: word = {6'h08, bus.req_rs, bus.req_rt, bus.req_imm};
      4'd12: word = {6'h0C, bus.req_rs, bus.req_rt, bus.req_imm};
      4'd13: word = {6'h0D, bus.req_rs, bus.req_rt, bus.req_imm};
      default: word = 32'h0;
    endcase
  end

  always_comb begin
    full    = (cnt_q == FULL);
    empty   = (cnt_q == '0);
    bus.req_ready = !full && (state_q != DRAIN);
    acc     = bus.req_valid && bus.req_ready;
    is_end  = (bus.req_op == 4'd15);
`ifdef INST_ENCODER_CHECK_EN
    drop    = (bus.req_op == 4'd14);
`else
    drop    = 1'b0;
`endif
    enq     = acc && !is_end && !drop;
    deq     = !empty && bus.imem_ready;
    load_ok = load_base && (state_q == IDLE) && empty;
    bus.imem_we    = !empty;
    bus.imem_wdata = empty ? 32'h0 : mem_q[rd_q];
    bus.imem_addr  = addr_q;
    done       = (state_q == DRAIN) && empty;
    word_count = wcnt_q;
    err_flag   = err_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (acc) state_d = is_end ? DRAIN : STREAM;
      STREAM:  if (acc && is_end) state_d = DRAIN;
      DRAIN:   if (empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_d   = enq ? wr_q + 1'b1 : wr_q;
    rd_d   = deq ? rd_q + 1'b1 : rd_q;
    cnt_d  = cnt_q;
    if (enq && !deq) cnt_d = cnt_q + 1'b1;
    else if (!enq && deq) cnt_d = cnt_q - 1'b1;
    addr_d = addr_q;
    wcnt_d = wcnt_q;
    if (load_ok) begin
      addr_d = base_addr & ~32'h3;
      wcnt_d = 16'h0;
    end else if (deq) begin
      addr_d = addr_q + 32'd4;
      if (wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
    end
`ifdef INST_ENCODER_CHECK_EN
    err_d = err_q
          | (acc && bus.req_op == 4'd14)
          | (load_ok && base_addr[1:0] != 2'b00);
`else
    err_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= 32'h0;
      wcnt_q  <= 16'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  // Storage needs no reset: wdata is gated to zero while empty.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_q] <= word;
  end
endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder and loader for the single-cycle MIPS core. It accepts symbolic instruction requests over a valid/ready handshake and encodes each into a 32-bit MIPS word using exactly the opcode/rt classes the core's control decoder recognises. Encoded words are buffered in a small FIFO and streamed into the instruction-memory write port at incrementing word addresses. It is used for program loading and for self-test program injection ahead of instruction fetch.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `load_base` input 1: load `base_addr` into the address counter.
- `base_addr` input 32: byte address of the first word to write.
- `req_valid` input 1: request present.
- `req_ready` output 1: request accepted this cycle when `req_valid` and `req_ready` are both 1.
- `req_op` input 4: operation select, coded below.
- `req_rs`, `req_rt`, `req_rd` input 5 each: register fields.
- `req_funct` input 6: R-type funct field.
- `req_imm` input 16: I-type immediate.
- `req_target` input 26: J-type target.
- `imem_we` output 1: write request; high whenever the FIFO is non-empty.
- `imem_addr` output 32: byte write address.
- `imem_wdata` output 32: encoded word at the FIFO head.
- `imem_ready` input 1: memory accepts the write when `imem_we` and `imem_ready` are both 1.
- `word_count` output 16: number of words written since the last `load_base`.
- `done` output 1: one-cycle pulse when a program has fully drained.
- `err_flag` output 1: sticky error flag (see Configuration).

## Operation
- `req_op` encoding (shamt is always 0):
  - 0 R-type: `{000000, rs, rt, rd, 00000, funct}`.
  - 1 lw: opcode 0x23. 2 sw: 0x2B. 3 beq: 0x04. 4 bne: 0x05.
  - 5 bgez: 0x01 with rt=1. 6 bgtz: 0x07 with rt=0. 7 blez: 0x06 with rt=0. 8 bltz: 0x01 with rt=0.
  - 9 j: 0x02. 10 jal: 0x03. 11 addi: 0x08. 12 andi: 0x0C. 13 ori: 0x0D.
  - 14: invalid.
  - 15: END marker. It writes nothing.
- I-type words are `{op, rs, rt, imm}`. For ops 5–8 the rt field is forced to the listed value and `req_rt` is ignored. J-type words are `{op, target}`.
- Encoding happens at enqueue. The FIFO stores finished 32-bit words.
- State machine:
  - IDLE: accepting a non-END request goes to STREAM. Accepting END goes to DRAIN.
  - STREAM: accepting END goes to DRAIN.
  - DRAIN: when the FIFO is empty, pulse `done` for one cycle and go to IDLE.
- `req_ready` = FIFO not full AND state ≠ DRAIN.
  - It does not depend on a same-cycle dequeue; there is no pass-through when full.
- `load_base` is honoured only in IDLE with the FIFO empty; otherwise it is ignored.
  - When honoured: the address counter takes `base_addr` with bits [1:0] cleared, and `word_count` clears.
- Each accepted write advances the address by 4, wrapping modulo 2^32, and increments `word_count`, which saturates at 0xFFFF.
- Simultaneous enqueue and dequeue with the FIFO non-full: both occur, and occupancy is unchanged.
- Reset mid-operation: the FIFO is emptied, pending words are lost, and state returns to IDLE.

## Timing
- Reset values:
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `word_count`=0, `done`=0, `err_flag`=0.
  - `req_ready`=1 after reset, since the FIFO is empty.
- Latency: a request accepted at edge N produces `imem_we`=1 with its word after edge N, i.e. in cycle N+1 at the earliest.
- `imem_wdata` and `imem_addr` are held stable while `imem_we`=1 and `imem_ready`=0.
- `done` asserts in the cycle after the last write is accepted. If END arrives with the FIFO empty, `done` asserts the cycle after END is accepted.
- Throughput: one word per cycle when `imem_ready` is held high.

## Configuration
- `INST_ENCODER_CHECK_EN` defined:
  - op 14 is dropped and not enqueued, and sets `err_flag`.
  - A honoured `load_base` with `base_addr[1:0]` ≠ 0 sets `err_flag`; the address is still aligned.
  - `err_flag` clears only on reset.
- Not defined:
  - op 14 encodes as 32'h00000000 (nop) and is written normally.
  - Misaligned base addresses are aligned silently.
  - `err_flag` is tied to 0.

## Test plan
- `load_base` 0x00400000, then R-type rd=3 rs=1 rt=2 funct=0x20, then END, with `imem_ready`=1 -> one write of 0x00221820 at 0x00400000, `word_count`=1, `done` pulse in the following cycle.
- addi rt=8 rs=0 imm=5, then lw rt=9 rs=29 imm=4, then bgez rs=4 imm=0xFFFF, then j target=0x0100000 -> words 0x20080005, 0x8FA90004, 0x0481FFFF, 0x08100000 at consecutive addresses +0, +4, +8, +12.
- bgtz rs=5 `req_rt`=7 imm=3 -> 0x1CA00003 (rt forced to 0).
- Hold `imem_ready`=0 and issue 5 requests with DEPTH=4 -> `req_ready` low after 4 accepts. Data is held stable. Releasing `imem_ready` drains the words in order.
- `load_base` 0xFFFFFFFC and write 2 words -> addresses 0xFFFFFFFC then 0x00000000. Assert `reset` mid-stream -> all outputs return to their reset values and `req_ready`=1.
- op 14 with the macro defined -> no write and `err_flag`=1. Without the macro -> 0x00000000 is written and `err_flag`=0.
